// File: rtl/oclib_csr_tree_arbiter.sv
// Round-robin CSR tree arbiter: Inputs masters share one downstream CSR target, one transaction in flight.
// Request -> out one cycle later; target response -> inFb one cycle later; hung targets answered by timeout.
package oclib_pkg;
  localparam bit False = 1'b0;
  localparam bit True  = 1'b1;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [7:0]  toblock;
    logic [31:0] address;
    logic [31:0] wdata;
  } csr_32_tree_s;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } csr_32_fb_s;
endpackage

module oclib_csr_tree_arbiter #(
  parameter type CsrType       = oclib_pkg::csr_32_tree_s,
  parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
  parameter int  Inputs        = 4,
  parameter int  TimeoutCycles = 1024,
  parameter bit  ResetSync     = oclib_pkg::False,
  parameter int  SyncCycles    = 3,
  parameter int  ResetPipeline = 0,
  localparam int GW            = (Inputs > 1) ? $clog2(Inputs) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  CsrType        in      [Inputs],
  output CsrFbType      inFb    [Inputs],
  output CsrType        out,
  input  CsrFbType      outFb,
  output logic [GW-1:0] grant,
  output logic          busy,
  output logic          timeout
);

  localparam int RstDepth = (ResetSync ? SyncCycles : 0) + ResetPipeline;
  localparam int RW       = 1 << GW;
  localparam int CW       = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] TimeoutLast = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  logic w_rst;

  generate
    if (RstDepth == 0) begin : g_rst_direct
      assign w_rst = reset;
    end else begin : g_rst_pipe
      logic [RstDepth-1:0] r_rst_pipe;
      always_ff @(posedge clock) begin
        r_rst_pipe[0] <= reset;
        for (int i = 1; i < RstDepth; i++) r_rst_pipe[i] <= r_rst_pipe[i-1];
      end
      assign w_rst = r_rst_pipe[RstDepth-1];
    end
  endgenerate

  state_e         r_state, w_state_nxt;
  CsrType         r_out, w_out_nxt, w_cap;
  CsrFbType       r_infb [Inputs];
  CsrFbType       w_infb_nxt [Inputs];
  CsrFbType       w_rsp;
  logic [GW-1:0]  r_grant, w_grant_nxt;
  logic [GW-1:0]  r_ptr, w_ptr_nxt;
  logic [GW-1:0]  w_win;
  logic           w_win_vld;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic           r_busy;
  logic           w_expire;
  logic [RW-1:0]  w_req;
  int             w_idx;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < Inputs; i++) w_req[i] = in[i].read || in[i].write;
  end

  // Search starts just past the last granted master so every requester is reached within Inputs turns.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    w_idx     = 0;
    for (int k = 1; k <= Inputs; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= Inputs) w_idx = w_idx - Inputs;
      if (!w_win_vld && w_req[GW'(w_idx)]) begin
        w_win_vld = 1'b1;
        w_win     = GW'(w_idx);
      end
    end
  end

  always_comb begin
    w_cap = '0;
    for (int i = 0; i < Inputs; i++) if (w_win == GW'(i)) w_cap = in[i];
  end

  assign w_expire = (TimeoutCycles != 0) && (r_cnt == TimeoutLast);

  always_comb begin
    w_state_nxt   = r_state;
    w_out_nxt     = r_out;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    w_rsp         = '0;
    for (int i = 0; i < Inputs; i++) w_infb_nxt[i] = '0;
    unique case (r_state)
      StIdle: begin
        w_out_nxt.read  = 1'b0;
        w_out_nxt.write = 1'b0;
        if (w_win_vld) begin
          w_out_nxt   = w_cap;
          w_grant_nxt = w_win;
          w_cnt_nxt   = '0;
          w_state_nxt = StIssue;
        end
      end
      StIssue: begin
        // A real response in the expiry cycle takes precedence over the timeout.
        if (outFb.ready) begin
          w_rsp.ready = 1'b1;
          w_rsp.error = outFb.error;
          w_rsp.rdata = r_out.read ? outFb.rdata : '0;
        end else if (w_expire) begin
          w_rsp.ready   = 1'b1;
          w_rsp.error   = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_rsp.ready) begin
          w_out_nxt.read  = 1'b0;
          w_out_nxt.write = 1'b0;
          w_state_nxt     = StDone;
        end
      end
      StDone: begin
        if (!w_req[r_grant]) begin
          w_ptr_nxt   = r_grant;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    for (int i = 0; i < Inputs; i++) if (r_grant == GW'(i)) w_infb_nxt[i] = w_rsp;
  end

  always_ff @(posedge clock) begin
    if (w_rst) begin
      r_state   <= StIdle;
      r_out     <= '0;
      r_grant   <= '0;
      r_ptr     <= GW'(Inputs - 1);
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < Inputs; i++) r_infb[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_out     <= w_out_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_busy    <= (w_state_nxt != StIdle);
      for (int i = 0; i < Inputs; i++) r_infb[i] <= w_infb_nxt[i];
    end
  end

  assign out     = r_out;
  assign grant   = r_grant;
  assign busy    = r_busy;
  assign timeout = r_timeout;
  always_comb for (int i = 0; i < Inputs; i++) inFb[i] = r_infb[i];

endmodule

// File: tb/tb_oclib_csr_tree_arbiter.sv
// Bench for oclib_csr_tree_arbiter: directed scenarios plus randomized traffic against a
// round-robin / timeout reference model; stimulus driven and outputs sampled on the falling edge.
module tb_oclib_csr_tree_arbiter;
  import oclib_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  csr_32_tree_s in_s [N];
  csr_32_fb_s   infb [N];
  csr_32_tree_s out_s;
  csr_32_fb_s   outfb;
  logic [1:0]   grant;
  logic         busy;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  oclib_csr_tree_arbiter #(.Inputs(N), .TimeoutCycles(TO)) dut (
    .clock  (clock),
    .reset  (reset),
    .in     (in_s),
    .inFb   (infb),
    .out    (out_s),
    .outFb  (outfb),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    outfb = '0;
    for (int i = 0; i < N; i++) in_s[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic out_vld();
    return out_s.read || out_s.write;
  endfunction

  function automatic csr_32_tree_s make_req(input logic wr);
    csr_32_tree_s r;
    r         = '0;
    r.read    = !wr;
    r.write   = wr;
    r.toblock = 8'($urandom);
    r.address = $urandom;
    r.wdata   = $urandom;
    return r;
  endfunction

  // Round-robin reference: first pending master strictly after the last one served.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [N-1:0] pend);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (pend[2'(idx)]) return 2'(idx);
    end
    return 2'd0;
  endfunction

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_vld()) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Target model: raises ready on issue cycle 'lat' (0 = first cycle out is valid); returns the
  // number of cycles out stayed valid and leaves the bench on the response cycle.
  task automatic run_txn(input int lat, input logic err, input logic [31:0] rd, output int held);
    held = 0;
    while (held < 64) begin
      if (held == lat) begin
        outfb.ready = 1'b1;
        outfb.error = err;
        outfb.rdata = rd;
      end
      held++;
      tick();
      outfb = '0;
      if (!out_vld()) break;
    end
  endtask

  function automatic int count_other_fb(input int skip);
    int nz = 0;
    for (int j = 0; j < N; j++) if (j != skip && infb[j] !== '0) nz++;
    return nz;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (out_s !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", out_s); end
    checks++; if (count_other_fb(-1) !== 0) begin failures++; $display("FAIL reset_infb nonzero=%0d exp=0", count_other_fb(-1)); end
    checks++; if (grant !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    reset = 1'b0;
  endtask

  task automatic test_read_single();
    csr_32_tree_s req;
    do_reset();
    req     = make_req(1'b0);
    in_s[2] = req;
    tick();
    checks++; if (out_s.read !== 1'b1) begin failures++; $display("FAIL t1_latency read got=%b exp=1", out_s.read); end
    checks++; if (grant !== 2'd2) begin failures++; $display("FAIL t1_grant got=%0d exp=2", grant); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", busy); end
    in_s[2].address = ~req.address;
    tick();
    tick();
    tick();
    checks++; if (out_s.read !== 1'b1 || out_s.address !== req.address) begin
      failures++; $display("FAIL t1_hold read=%b addr=%h exp read=1 addr=%h", out_s.read, out_s.address, req.address);
    end
    checks++; if (infb[2].ready !== 1'b0) begin failures++; $display("FAIL t1_early_ready got=%b exp=0", infb[2].ready); end
    outfb.ready = 1'b1;
    outfb.error = 1'b0;
    outfb.rdata = 32'hDEADBEEF;
    tick();
    outfb = '0;
    checks++; if (infb[2].ready !== 1'b1 || infb[2].error !== 1'b0 || infb[2].rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL t1_rsp got=%h exp ready=1 error=0 rdata=deadbeef", infb[2]);
    end
    checks++; if (out_s.read !== 1'b0) begin failures++; $display("FAIL t1_out_drop got=%b exp=0", out_s.read); end
    checks++; if (count_other_fb(2) !== 0) begin failures++; $display("FAIL t1_other_fb nonzero=%0d exp=0", count_other_fb(2)); end
    in_s[2] = '0;
    tick();
    checks++; if (infb[2].ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL t1_pulse ready=%b busy=%b exp 0 0", infb[2].ready, busy);
    end
  endtask

  task automatic test_all_write();
    csr_32_tree_s req [N];
    int           order [5] = '{0, 1, 2, 3, 0};
    int           held;
    logic         ok;
    logic [1:0]   g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req[i]  = make_req(1'b1);
      in_s[i] = req[i];
    end
    for (int t = 0; t < 5; t++) begin
      wait_valid(ok);
      g = grant;
      checks++; if (!ok || int'(g) !== order[t]) begin
        failures++; $display("FAIL t2_order step=%0d ok=%b got=%0d exp=%0d", t, ok, g, order[t]);
      end
      checks++; if (out_s.write !== 1'b1 || out_s.wdata !== req[g].wdata) begin
        failures++; $display("FAIL t2_wdata step=%0d got=%h exp=%h", t, out_s.wdata, req[g].wdata);
      end
      if (g == 2'd3) begin
        req[0]  = make_req(1'b1);
        in_s[0] = req[0];
      end
      run_txn(1, 1'b0, $urandom | 32'h1, held);
      checks++; if (held !== 2 || infb[g].ready !== 1'b1 || infb[g].rdata !== 32'h0 || infb[g].error !== 1'b0) begin
        failures++; $display("FAIL t2_rsp step=%0d held=%0d fb=%h exp held=2 ready=1 rdata=0", t, held, infb[g]);
      end
      in_s[g] = '0;
    end
    tick();
  endtask

  task automatic test_timeout();
    csr_32_tree_s req3;
    logic [31:0]  rd;
    int           held;
    logic         ok;
    do_reset();
    in_s[1] = make_req(1'b0);
    req3    = make_req(1'b1);
    in_s[3] = req3;
    wait_valid(ok);
    checks++; if (!ok || grant !== 2'd1) begin failures++; $display("FAIL t3_grant ok=%b got=%0d exp=1", ok, grant); end
    run_txn(1000, 1'b0, 32'h0, held);
    checks++; if (held !== TO) begin failures++; $display("FAIL t3_cycles got=%0d exp=%0d", held, TO); end
    checks++; if (infb[1].ready !== 1'b1 || infb[1].error !== 1'b1 || infb[1].rdata !== 32'h0) begin
      failures++; $display("FAIL t3_rsp got=%h exp ready=1 error=1 rdata=0", infb[1]);
    end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL t3_pulse got=%b exp=1", timeout); end
    in_s[1] = '0;
    tick();
    checks++; if (timeout !== 1'b0 || infb[1].ready !== 1'b0) begin
      failures++; $display("FAIL t3_pulse_end timeout=%b ready=%b exp 0 0", timeout, infb[1].ready);
    end
    wait_valid(ok);
    checks++; if (!ok || grant !== 2'd3 || out_s !== req3) begin
      failures++; $display("FAIL t3_next ok=%b grant=%0d out=%h exp grant=3 out=%h", ok, grant, out_s, req3);
    end
    rd = $urandom;
    run_txn(0, 1'b0, rd, held);
    checks++; if (held !== 1 || infb[3].ready !== 1'b1 || infb[3].error !== 1'b0 || timeout !== 1'b0) begin
      failures++; $display("FAIL t3_next_rsp held=%0d fb=%h timeout=%b exp held=1 ready=1 error=0 timeout=0", held, infb[3], timeout);
    end
    in_s[3] = '0;
    tick();
  endtask

  task automatic test_hold();
    logic [31:0] rd;
    int          held, issues, pulses;
    logic        ok;
    do_reset();
    in_s[1] = make_req(1'b0);
    wait_valid(ok);
    checks++; if (!ok || grant !== 2'd1) begin failures++; $display("FAIL t4_grant ok=%b got=%0d exp=1", ok, grant); end
    in_s[3] = make_req(1'b1);
    rd = $urandom;
    run_txn(2, 1'b0, rd, held);
    checks++; if (infb[1].ready !== 1'b1 || infb[1].rdata !== rd) begin
      failures++; $display("FAIL t4_rsp got=%h exp ready=1 rdata=%h", infb[1], rd);
    end
    issues = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_vld()) issues++;
      if (infb[1].ready) pulses++;
    end
    checks++; if (issues !== 0 || pulses !== 0) begin
      failures++; $display("FAIL t4_double_issue issues=%0d pulses=%0d exp 0 0", issues, pulses);
    end
    in_s[1] = '0;
    tick();
    checks++; if (out_vld() !== 1'b0) begin failures++; $display("FAIL t4_early_grant got=1 exp=0"); end
    tick();
    checks++; if (out_s.write !== 1'b1 || grant !== 2'd3) begin
      failures++; $display("FAIL t4_regrant write=%b grant=%0d exp 1 3", out_s.write, grant);
    end
    run_txn(0, 1'b0, 32'h0, held);
    in_s[3] = '0;
    tick();
  endtask

  task automatic test_error();
    logic [31:0] rd;
    int          lat, held;
    logic        ok;
    do_reset();
    in_s[0] = make_req(1'b1);
    wait_valid(ok);
    lat = $urandom_range(0, 5);
    rd  = $urandom | 32'h1;
    run_txn(lat, 1'b1, rd, held);
    checks++; if (!ok || held !== lat + 1 || infb[0].ready !== 1'b1 || infb[0].error !== 1'b1 || infb[0].rdata !== 32'h0) begin
      failures++; $display("FAIL t5_wr_err held=%0d fb=%h exp held=%0d ready=1 error=1 rdata=0", held, infb[0], lat + 1);
    end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL t5_no_timeout got=%b exp=0", timeout); end
    in_s[0] = '0;
    tick();
    in_s[0] = make_req(1'b0);
    wait_valid(ok);
    run_txn(0, 1'b1, rd, held);
    checks++; if (infb[0].ready !== 1'b1 || infb[0].error !== 1'b1 || infb[0].rdata !== rd) begin
      failures++; $display("FAIL t5_rd_err got=%h exp ready=1 error=1 rdata=%h", infb[0], rd);
    end
    in_s[0] = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int   held;
    logic ok;
    do_reset();
    in_s[1] = make_req(1'b0);
    wait_valid(ok);
    tick();
    reset       = 1'b1;
    outfb.ready = 1'b1;
    outfb.rdata = $urandom;
    tick();
    checks++; if (out_vld() !== 1'b0 || busy !== 1'b0 || grant !== 2'd0 || timeout !== 1'b0) begin
      failures++; $display("FAIL t6_abandon vld=%b busy=%b grant=%0d timeout=%b exp all 0", out_vld(), busy, grant, timeout);
    end
    checks++; if (count_other_fb(-1) !== 0) begin failures++; $display("FAIL t6_infb nonzero=%0d exp=0", count_other_fb(-1)); end
    outfb   = '0;
    in_s[1] = '0;
    in_s[2] = make_req(1'b0);
    in_s[0] = make_req(1'b1);
    tick();
    reset = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || grant !== 2'd0) begin failures++; $display("FAIL t6_first ok=%b got=%0d exp=0", ok, grant); end
    run_txn(0, 1'b0, 32'h0, held);
    in_s[0] = '0;
    wait_valid(ok);
    checks++; if (!ok || grant !== 2'd2) begin failures++; $display("FAIL t6_second ok=%b got=%0d exp=2", ok, grant); end
    run_txn(0, 1'b0, 32'h0, held);
    in_s[2] = '0;
    tick();
  endtask

  task automatic test_random();
    csr_32_tree_s req [N];
    csr_32_fb_s   exp_rsp;
    logic [N-1:0] pend;
    logic [1:0]   last, exp;
    logic [31:0]  rd;
    logic         err, ok, to;
    int           lat, held, exp_held, dropped, pick;
    do_reset();
    last    = 2'(N - 1);
    pend    = '0;
    dropped = -1;
    for (int t = 0; t < 60; t++) begin
      // A master that just dropped must stay low for a cycle, so it is not re-raised here.
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && i != dropped && $urandom_range(0, 1) == 1) begin
          req[i]  = make_req(1'($urandom));
          in_s[i] = req[i];
          pend[i] = 1'b1;
        end
      end
      if (pend == '0) begin
        pick       = (dropped + 1 + $urandom_range(0, N - 2)) % N;
        req[pick]  = make_req(1'($urandom));
        in_s[pick] = req[pick];
        pend[pick] = 1'b1;
      end
      exp = rr_pick(last, pend);
      wait_valid(ok);
      checks++; if (!ok || grant !== exp || out_s !== req[exp]) begin
        failures++; $display("FAIL rnd_grant txn=%0d ok=%b grant=%0d out=%h exp grant=%0d out=%h", t, ok, grant, out_s, exp, req[exp]);
      end
      lat = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
      err = 1'($urandom);
      rd  = $urandom;
      run_txn(lat, err, rd, held);
      to            = (lat >= TO);
      exp_held      = to ? TO : lat + 1;
      exp_rsp.ready = 1'b1;
      exp_rsp.error = to ? 1'b1 : err;
      exp_rsp.rdata = (to || req[exp].write) ? 32'h0 : rd;
      checks++; if (held !== exp_held || infb[exp] !== exp_rsp || timeout !== to) begin
        failures++; $display("FAIL rnd_rsp txn=%0d lat=%0d held=%0d fb=%h to=%b exp held=%0d fb=%h to=%b", t, lat, held, infb[exp], timeout, exp_held, exp_rsp, to);
      end
      checks++; if (count_other_fb(int'(exp)) !== 0) begin
        failures++; $display("FAIL rnd_other_fb txn=%0d nonzero=%0d exp=0", t, count_other_fb(int'(exp)));
      end
      in_s[exp] = '0;
      pend[exp] = 1'b0;
      last      = exp;
      dropped   = int'(exp);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read_single();
    test_all_write();
    test_timeout();
    test_hold();
    test_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
